// File: rtl/dfnf_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dfnf_pkg
//  Description : Shared constants and stage-record layout for the negedge
//                pipeline register (dfnf_pipe) and its stage cell.
//  Revision    : 1.0 - initial release
// ============================================================================
package dfnf_pkg;

  localparam int DFNF_WIDTH_DEF = 8;
  localparam int DFNF_DEPTH_DEF = 2;
  localparam int DFNF_CNT_W_DEF = 4;
  localparam int DFNF_WIDTH_MAX = 64;

  // Stage word layout, LSB first: tag, valid, then the data word.
  localparam int STG_TAG_BIT  = 0;
  localparam int STG_VLD_BIT  = 1;
  localparam int STG_DATA_LSB = 2;

  // Reference record at the maximum width; the RTL carries the same layout
  // as a flat vector sized to the actual WIDTH.
  typedef struct packed {
    logic [DFNF_WIDTH_MAX-1:0] data;
    logic                      vld;
    logic                      tag;
  } dfnf_stage_t;

  // Width of one packed stage word for a given data width.
  function automatic int stg_w(input int width);
    return width + STG_DATA_LSB;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dfnf_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : dfnf_stage
//  Description : One falling-edge pipeline stage holding {data, vld, tag},
//                with synchronous active-low reset and hold-on-stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module dfnf_stage
  import dfnf_pkg::*;
#(
  parameter int               WIDTH     = DFNF_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic                          en,
  input  logic [WIDTH+STG_DATA_LSB-1:0] d,
  output logic [WIDTH+STG_DATA_LSB-1:0] q
);

  // Capture on the falling edge; reset loads RESET_VAL with vld/tag cleared
  // (concatenation order matches the data|vld|tag field offsets).
  always_ff @(negedge clk) begin
    if (!rst_b) begin
      q <= {RESET_VAL, 1'b0, 1'b0};
    end else if (en) begin
      q <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dfnf_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : dfnf_pipe
//  Description : DEPTH-stage, WIDTH-bit negedge pipeline register with stall,
//                per-word valid, violation tag, sticky error and saturating
//                violation counter; true and complement data outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module dfnf_pipe
  import dfnf_pkg::*;
#(
  parameter int               WIDTH     = DFNF_WIDTH_DEF,
  parameter int               DEPTH     = DFNF_DEPTH_DEF,
  parameter int               CNT_W     = DFNF_CNT_W_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK2,
  input  logic             RST_b,
  input  logic             EN,
  input  logic [WIDTH-1:0] DATA1,
  input  logic             VLD_IN,
  input  logic             NOTIFY,
  input  logic             CLR_ERR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_b,
  output logic             VLD_OUT,
  output logic             ERR_OUT,
  output logic             ERR_STICKY,
  output logic [CNT_W-1:0] VIOL_CNT
);

  localparam int               SW      = stg_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // stg[0] is the incoming word, stg[i+1] the output of stage i.
  logic [SW-1:0]    stg [DEPTH+1];
  logic             viol_evt;
  logic             sticky;
  logic [CNT_W-1:0] cnt;

  // A tag is only meaningful for a valid word.
  assign stg[0]   = {DATA1, VLD_IN, NOTIFY & VLD_IN};
  assign viol_evt = EN & VLD_IN & NOTIFY;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      dfnf_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .clk   (CLK2),
        .rst_b (RST_b),
        .en    (EN),
        .d     (stg[i]),
        .q     (stg[i+1])
      );
    end
  endgenerate

  // Sticky error and saturating counter; a violation beats a same-edge clear.
  always_ff @(negedge CLK2) begin
    if (!RST_b) begin
      sticky <= 1'b0;
      cnt    <= '0;
    end else if (viol_evt) begin
      sticky <= 1'b1;
      if (CLR_ERR)             cnt <= CNT_ONE;
      else if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
    end else if (CLR_ERR) begin
      sticky <= 1'b0;
      cnt    <= '0;
    end
  end

  assign Q          = stg[DEPTH][STG_DATA_LSB +: WIDTH];
  assign Q_b        = ~Q;
  assign VLD_OUT    = stg[DEPTH][STG_VLD_BIT];
  assign ERR_OUT    = stg[DEPTH][STG_TAG_BIT];
  assign ERR_STICKY = sticky;
  assign VIOL_CNT   = cnt;

endmodule
`default_nettype wire

// File: doc/dfnf_pipe.md
Name: dfnf_pipe

Overview:
- Parametrised successor to the single-bit negative-edge Q/Q_b flip-flop cell.
- DEPTH-stage, WIDTH-bit pipeline register, captured on the falling edge of CLK2, with stage enable (stall), per-word valid, and true/complement outputs.
- Adds timing-violation tracking: an externally supplied NOTIFY pulse tags the captured word as corrupt; the tag travels with the word, sets a sticky error and increments a saturating violation counter.
- Sits between negedge-launched datapath logic and downstream consumers that must know which words were captured under a violation.

Parameters:
- WIDTH, 8: data word width, 1 to 64.
- DEPTH, 2: number of pipeline stages, 1 to 8; equals latency in CLK2 falling edges.
- CNT_W, 4: width of the violation counter.
- RESET_VAL, 0: reset value of every data stage (WIDTH bits).

Ports:
- CLK2, input, 1: clock; all state changes on its falling edge.
- RST_b, input, 1: synchronous active-low reset, sampled on the falling edge of CLK2.
- EN, input, 1: 1 = pipeline advances; 0 = every stage holds.
- DATA1, input, WIDTH: data word to capture.
- VLD_IN, input, 1: DATA1 is a valid word.
- NOTIFY, input, 1: timing-violation flag for the current capture, from the checker.
- CLR_ERR, input, 1: clears the sticky error and the counter.
- Q, output, WIDTH: last-stage data.
- Q_b, output, WIDTH: bitwise complement of Q.
- VLD_OUT, output, 1: last-stage valid.
- ERR_OUT, output, 1: last-stage corrupt tag.
- ERR_STICKY, output, 1: a violation was captured since the last reset or clear.
- VIOL_CNT, output, CNT_W: saturating count of tagged captures.

Behaviour:
- All registers update only on the falling edge of CLK2. No rising-edge activity.
- Reset: if RST_b = 0 at a falling edge:
  - every data stage is loaded with RESET_VAL;
  - every valid bit and tag bit is cleared to 0;
  - ERR_STICKY is cleared to 0 and VIOL_CNT to 0.
  - Reset overrides EN, NOTIFY and CLR_ERR. Reset mid-stream discards in-flight words.
- Outputs after reset: Q = RESET_VAL, Q_b = ~RESET_VAL, VLD_OUT = 0, ERR_OUT = 0.
- Advance (EN = 1):
  - stage0 captures {DATA1, VLD_IN, NOTIFY & VLD_IN};
  - stage i captures stage i-1 for i = 1 to DEPTH-1.
  - Data shifts even when valid = 0 (bubbles propagate).
- Hold (EN = 0): all data, valid and tag bits hold. NOTIFY is ignored and not counted.
- Latency: a word presented at falling edge n appears on Q/VLD_OUT/ERR_OUT after falling edge n+DEPTH-1, provided EN = 1 at every edge in between. With DEPTH = 1, it appears right after the capturing edge.
- Q_b is combinational ~Q with no extra register, so Q and Q_b always switch in the same edge window.
- Violation event:
  - Definition: EN = 1, VLD_IN = 1 and NOTIFY = 1 at a falling edge.
  - Effect: ERR_STICKY <= 1, and VIOL_CNT <= VIOL_CNT + 1, saturating at 2^CNT_W - 1 (no wrap).
  - NOTIFY with VLD_IN = 0 is ignored.
- Clear:
  - CLR_ERR = 1 with no violation event: ERR_STICKY <= 0, VIOL_CNT <= 0.
  - CLR_ERR = 1 together with a violation event: the set wins, so ERR_STICKY = 1 and VIOL_CNT = 1.
  - CLR_ERR does not alter in-flight tags.
- ERR_OUT is simply the last-stage tag and is not masked by VLD_OUT. It can only be 1 when VLD_OUT is 1.
- X on inputs is not modelled beyond plain RTL semantics. No UDP is used; the block is synthesizable.

Decomposition:
- Package dfnf_pkg holds:
  - default constants DFNF_WIDTH_DEF, DFNF_DEPTH_DEF, DFNF_CNT_W_DEF;
  - the stage record typedef {data, vld, tag} as a packed struct parametrised through the package maximum width, or equivalently as fixed field-offset constants.
- One sub-module, dfnf_stage: a single negedge stage with sync active-low reset, enable, and data/vld/tag.
  - The top instantiates DEPTH copies in a generate chain.
  - The violation counter and sticky logic live in the top.

Test Plan:
- Reset: RST_b = 0 for 2 falling edges with WIDTH = 8, RESET_VAL = 8'hA5 -> Q = A5, Q_b = 5A, VLD_OUT = 0, ERR_OUT = 0, ERR_STICKY = 0, VIOL_CNT = 0.
- Latency: DEPTH = 3, EN = 1, DATA1 = 8'h3C with VLD_IN = 1 at edge n, then bubbles -> Q = 3C, Q_b = C3 and VLD_OUT = 1 exactly after edge n+2, and VLD_OUT = 0 after edge n+3.
- Stall: EN = 0 for 4 edges mid-stream with words 11, 22, 33 in flight -> Q holds steady; NOTIFY = 1 during the stall leaves VIOL_CNT unchanged; after EN returns, words exit in order 11, 22, 33 with no loss.
- Violation tag: word 8'h77 captured with NOTIFY = 1 -> ERR_OUT = 1 exactly when Q = 77, neighbouring words show ERR_OUT = 0, ERR_STICKY = 1, VIOL_CNT = 1.
- Saturation and clear: CNT_W = 2 with 5 violating captures -> VIOL_CNT = 3; then CLR_ERR = 1 together with a violation -> ERR_STICKY = 1, VIOL_CNT = 1; then CLR_ERR alone -> 0 and 0.
- Reset mid-operation: RST_b = 0 for 1 edge while 3 valid words are in flight -> all flushed, VLD_OUT = 0 for the following DEPTH edges unless new words are injected.
